// File: rtl/mdu_pkg.sv
// Shared op-code encoding, legality check and signed-minimum helpers for iter_mdu.
// ITER_MDU_MACC_EN enables the accumulate/subtract op codes 4-7.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MADDU = 3'd4,
    OP_MADD  = 3'd5,
    OP_MSUBU = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [31:0] SIGNED_MIN_32 = 32'h8000_0000;

`ifdef ITER_MDU_MACC_EN
  localparam bit MACC_EN = 1'b1;
`else
  localparam bit MACC_EN = 1'b0;
`endif

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

  function automatic logic op_legal(input op_e op);
    return !op[2] || MACC_EN;
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iteration datapath shared by multiply and divide: counter, partial
// product / partial remainder (hi) and operand shift register (lo).
module mdu_shift_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  assign done = (cnt == CW'(WIDTH));

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    rem_shift = {hi, lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (div_mode) begin
      // Partial remainder stays below the divisor, so bit WIDTH of the
      // difference is a clean borrow flag for the restore decision.
      if (!rem_diff[WIDTH]) begin
        hi_nx = rem_diff[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = rem_shift[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      b_q <= '0;
      hi  <= '0;
      lo  <= '0;
    end else if (load) begin
      cnt <= '0;
      b_q <= b;
      hi  <= '0;
      lo  <= a;
    end else if (run && !done) begin
      cnt <= cnt + CW'(1);
      hi  <= hi_nx;
      lo  <= lo_nx;
    end
  end

endmodule

// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// ITER_MDU_MACC_EN enables MADD/MADDU/MSUB/MSUBU accumulation.
module iter_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [2:0]       Op,
  input  logic             Start,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [WIDTH-1:0] MIN = WIDTH'(signed_min(WIDTH));

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e state, state_nx;

  logic             accept;
  logic             commit;
  logic             core_done;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             in_neg1;
  logic             in_neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  op_e              op_q;
  logic             neg1_q;
  logic             neg2_q;
  logic             d2_zero_q;
  logic             is_div;
  logic             sign_flip;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (core_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state == S_RUN);
    accept = (state == S_IDLE) && Start && !We && op_legal(op_e'(Op));
    commit = (state == S_RUN) && core_done;
  end

  always_comb begin
    in_neg1 = Op[0] && ((D1 & MIN) != '0);
    in_neg2 = Op[0] && ((D2 & MIN) != '0);
    mag1    = in_neg1 ? -D1 : D1;
    mag2    = in_neg2 ? -D2 : D2;
  end

  // The core keeps the operand magnitudes; only signs, zero divisor and Op
  // are latched here for the commit-time fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_MULTU;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      d2_zero_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op_e'(Op);
      neg1_q    <= in_neg1;
      neg2_q    <= in_neg2;
      d2_zero_q <= (D2 == '0);
    end
  end

  assign is_div = op_q inside {OP_DIVU, OP_DIV};

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .run      (Busy),
    .div_mode (is_div),
    .a        (mag1),
    .b        (mag2),
    .done     (core_done),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  always_comb begin
    sign_flip = neg1_q ^ neg2_q;
    prod      = {core_hi, core_lo};
    if (sign_flip) prod = -prod;
    quo       = sign_flip ? -core_lo : core_lo;
    rem       = neg1_q ? -core_hi : core_hi;
    mul_res   = prod;
`ifdef ITER_MDU_MACC_EN
    if (op_q[2]) mul_res = op_q[1] ? ({HI, LO} - prod) : ({HI, LO} + prod);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (!is_div) begin
        {HI, LO} <= mul_res;
      end else if (!d2_zero_q) begin
        HI <= rem;
        LO <= quo;
      end
    end else if (We && !Busy) begin
      if (HiLo) HI <= D1;
      else      LO <= D1;
    end
  end

endmodule

// File: tb/tb_iter_mdu.sv
// Scoreboard bench for iter_mdu (WIDTH=32); honours ITER_MDU_MACC_EN.
module tb_iter_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] D1 = '0;
  logic [31:0] D2 = '0;
  logic [2:0]  Op = '0;
  logic        Start = 1'b0;
  logic        We = 1'b0;
  logic        HiLo = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  iter_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .D1    (D1),
    .D2    (D2),
    .Op    (Op),
    .Start (Start),
    .We    (We),
    .HiLo  (HiLo),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb.push_back(e);
  endtask

  task automatic start_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic expect_busy);
    @(posedge clk); #1;
    Op = op; D1 = a; D2 = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    check({name, "_busy_rise"}, 64'(Busy), 64'(expect_busy));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!Busy) break;
    end
    if (Busy) check({name, "_timeout"}, 64'(Busy), 64'd0);
  endtask

  task automatic write_reg(input logic hilo, input logic [31:0] v);
    @(posedge clk); #1;
    We = 1'b1; HiLo = hilo; D1 = v;
    @(posedge clk); #1;
    We = 1'b0;
  endtask

  // Monitor: Busy length and committed HI/LO checked on every falling Busy.
  logic        prev_busy = 1'b0;
  int unsigned busy_cycles = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy   = 1'b0;
      busy_cycles = 0;
    end else begin
      if (Busy) busy_cycles++;
      if (prev_busy && !Busy) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_cycles"}, 64'(busy_cycles), 64'd33);
          check({e.name, "_hilo"}, {HI, LO}, {e.hi, e.lo});
        end
        busy_cycles = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    #2;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    push("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    start_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("mult_neg2x3");

    push("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op("div_neg7by2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_neg7by2");

    push("divu_by_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op("divu_by_zero", 3'd2, 32'd7, 32'd0, 1'b1);
    wait_idle("divu_by_zero");

    push("div_min_by_m1", 32'h0, SIGNED_MIN_32);
    start_op("div_min_by_m1", 3'd3, SIGNED_MIN_32, 32'hFFFF_FFFF, 1'b1);
    wait_idle("div_min_by_m1");

    push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    start_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle("multu_max");

    push("divu_100by7", 32'd2, 32'd14);
    start_op("divu_100by7", 3'd2, 32'd100, 32'd7, 1'b1);
    wait_idle("divu_100by7");

    push("mult_neg3xneg5", 32'd0, 32'd15);
    start_op("mult_neg3xneg5", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1);
    wait_idle("mult_neg3xneg5");

    push("div_7byneg2", 32'd1, 32'hFFFF_FFFD);
    start_op("div_7byneg2", 3'd3, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_idle("div_7byneg2");

    write_reg(1'b1, 32'd0);
    write_reg(1'b0, 32'd10);
    check("mthi", 64'(HI), 64'd0);
    check("mtlo", 64'(LO), 64'd10);

`ifdef ITER_MDU_MACC_EN
    push("msubu_3x4", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    start_op("msubu_3x4", 3'd6, 32'd3, 32'd4, 1'b1);
    wait_idle("msubu_3x4");
    push("madd_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    start_op("madd_neg2x3", 3'd5, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle("madd_neg2x3");
`else
    start_op("msubu_illegal", 3'd6, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    check("msubu_illegal_busy", 64'(Busy), 64'd0);
    check("msubu_illegal_hilo", {HI, LO}, {32'd0, 32'd10});
`endif

    push("we_during_busy", 32'd0, 32'd6);
    start_op("we_during_busy", 3'd0, 32'd2, 32'd3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    We = 1'b1; HiLo = 1'b1; D1 = 32'h55;
    @(posedge clk); #1;
    We = 1'b0;
    wait_idle("we_during_busy");

    @(posedge clk); #1;
    Op = 3'd0; D1 = 32'h77; D2 = 32'd3; Start = 1'b1; We = 1'b1; HiLo = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; We = 1'b0;
    check("start_we_lo", 64'(LO), 64'h77);
    check("start_we_busy", 64'(Busy), 64'd0);
    @(posedge clk); #1;
    check("start_we_busy_later", 64'(Busy), 64'd0);

    start_op("divu_aborted", 3'd2, 32'd100, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    push("multu_after_reset", 32'd0, 32'd6);
    Op = 3'd0; D1 = 32'd2; D2 = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    check("first_start_after_reset", 64'(Busy), 64'd1);
    wait_idle("multu_after_reset");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO; legal values are even and 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port D1, input, WIDTH bits: dividend or multiplicand, and the data for HI/LO writes.
REQ-005 The block SHALL have port D2, input, WIDTH bits: divisor or multiplier.
REQ-006 The block SHALL have port Op, input, 3 bits: operation code, sampled when a start is accepted.
REQ-007 The block SHALL have port Start, input, 1 bit: requests an operation.
REQ-008 The block SHALL have port We, input, 1 bit: direct write to HI or LO.
REQ-009 The block SHALL have port HiLo, input, 1 bit: write target, 1 for HI, 0 for LO.
REQ-010 The block SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have ports HI and LO, output, WIDTH bits each: the result registers.

Function
REQ-012 Op codes SHALL be: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB.
REQ-013 A start SHALL be accepted only when Start=1, Busy=0, We=0 and Op is a legal code.
REQ-014 On acceptance, the block SHALL latch D1, D2 and Op, and Busy SHALL rise on the same edge.
REQ-015 Busy SHALL stay high for exactly WIDTH+1 cycles (WIDTH iterations plus one sign-fix/commit cycle), for every Op.
REQ-016 HI/LO SHALL update, and Busy SHALL fall, on the same edge.
REQ-017 Multiply SHALL be radix-2 shift-add over operand magnitudes, with the product negated when the signed operand signs differ.
REQ-018 Multiply SHALL write {HI,LO} with the full 2*WIDTH product.
REQ-019 Divide SHALL be restoring radix-2 over magnitudes.
REQ-020 Divide SHALL write LO with the quotient and HI with the remainder.
REQ-021 For signed divide, the quotient sign SHALL be the XOR of the operand signs, and the remainder SHALL take the dividend's sign.
REQ-022 Signed divide of MIN by -1 SHALL give LO=MIN and HI=0.
REQ-023 Divide with D2=0 SHALL run the full WIDTH+1 cycles and SHALL leave HI/LO unchanged.
REQ-024 MADD/MADDU SHALL set {HI,LO} to {HI,LO} plus the product; MSUB/MSUBU SHALL set it to {HI,LO} minus the product.
REQ-025 For MADD/MADDU/MSUB/MSUBU, {HI,LO} SHALL be sampled at the commit edge, and the arithmetic SHALL be modulo 2^(2*WIDTH).
REQ-026 When We=1 and Busy=0, HI or LO SHALL be written with D1 as selected by HiLo.
REQ-027 We=1 while Busy=1 SHALL be ignored.
REQ-028 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-029 When Start and We are both 1 while idle, the write SHALL win and the start SHALL be dropped.

Reset
REQ-030 When rst is asserted, HI, LO, the iteration counter and the latched operands SHALL clear to 0 and Busy SHALL clear to 0, immediately and without waiting for clk.
REQ-031 Reset during an operation SHALL abort it with no partial commit.
REQ-032 The first start SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-033 With macro ITER_MDU_MACC_EN defined, Op codes 4-7 SHALL perform accumulate/subtract as in REQ-024 and REQ-025.
REQ-034 Without ITER_MDU_MACC_EN, Op codes 4-7 SHALL be illegal: Start is ignored, Busy stays 0, and no accumulator adder is synthesised.

Structure
REQ-035 Op-code constants, a legality function and the signed MIN constant SHALL live in shared package mdu_pkg.
REQ-036 Sub-module mdu_shift_core SHALL hold the shared iteration datapath (counter, partial remainder/product, shift register).
REQ-037 The top level SHALL hold the operand latch, sign fix, accumulate and HI/LO registers.

Verification (WIDTH=32)
REQ-038 The bench SHALL check: MULT D1=0xFFFFFFFE, D2=3 -> after 33 Busy cycles, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-039 The bench SHALL check: DIV D1=-7, D2=2 -> LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); and DIVU 7/0 -> HI/LO unchanged with Busy high for 33 cycles.
REQ-040 The bench SHALL check: DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000 and HI=0.
REQ-041 The bench SHALL check: with the macro, MTHI 0 and MTLO 10, then MSUBU 3*4 -> HI=0xFFFFFFFF and LO=0xFFFFFFFE; without the macro, the same Op leaves Busy=0.
REQ-042 The bench SHALL check: We=1, HiLo=1, D1=0x55 while Busy -> HI unaffected by the write; Start and We together while idle -> write done and Busy stays 0.
REQ-043 The bench SHALL check: rst asserted mid-DIVU, between clock edges -> Busy, HI and LO read 0 before the next edge, and a new MULTU 2*3 after reset gives LO=6.
